// File: rtl/debug_dump_unit_pkg.sv
// Shared command codes, FSM states and dump-item layout for the debug dump unit.
package debug_dump_unit_pkg;

  // Host command codes carried on i_cmd.
  typedef enum logic [1:0] {
    DBG_CMD_STOP = 2'b00,
    DBG_CMD_STEP = 2'b01,
    DBG_CMD_RUN  = 2'b10,
    DBG_CMD_DUMP = 2'b11
  } dbg_cmd_e;

  // Top-level controller states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STEP    = 3'd1,
    ST_RUN     = 3'd2,
    ST_SELECT  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_SEND    = 3'd5
  } dbg_state_e;

  // Dump item layout: PC, ALU result, 32 registers, then data memory words.
  localparam int DBG_ITEM_PC        = 0;
  localparam int DBG_ITEM_ALU       = 1;
  localparam int DBG_ITEM_REG_BASE  = 2;
  localparam int DBG_ITEM_MEM_BASE  = 34;
  localparam int DBG_BYTES_PER_WORD = 4;
  localparam int DBG_WORD_W         = 8 * DBG_BYTES_PER_WORD;

endpackage

// File: rtl/debug_dump_unit_word_serializer.sv
// Loads one word and streams it as MSB-first bytes over a valid/ready link.
module debug_word_serializer
  import debug_dump_unit_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [DBG_WORD_W-1:0] i_word,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_done
);

  localparam logic [1:0] LAST_BYTE = 2'(DBG_BYTES_PER_WORD - 1);

  logic [DBG_WORD_W-1:0] r_shift;
  logic [1:0]            r_count;
  logic [7:0]            r_data;
  logic                  r_valid;

  // Load presents the top byte at once; each handshake advances to the next byte.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= {i_word[DBG_WORD_W-9:0], 8'h00};
      r_data  <= i_word[DBG_WORD_W-1 -: 8];
      r_count <= '0;
      r_valid <= 1'b1;
    end else if (r_valid && i_tx_ready) begin
      if (r_count == LAST_BYTE) begin
        r_valid <= 1'b0;
      end else begin
        r_data  <= r_shift[DBG_WORD_W-1 -: 8];
        r_shift <= r_shift << 8;
        r_count <= r_count + 2'd1;
      end
    end
  end

  assign o_tx_data  = r_data;
  assign o_tx_valid = r_valid;
  // Done coincides with the final handshake so the controller moves on that edge.
  assign o_done     = r_valid & i_tx_ready & (r_count == LAST_BYTE);

endmodule

// File: rtl/debug_dump_unit.sv
// Debug controller: runs STOP/STEP/RUN/DUMP and streams a frozen pipeline snapshot.
module debug_dump_unit
  import debug_dump_unit_pkg::*;
#(
  parameter int NB              = 32,
  parameter int TAM_DATA_MEMORY = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cmd_valid,
  input  logic [1:0]    i_cmd,
  output logic          o_cmd_ready,
  input  logic          i_halt,
  output logic          o_step,
  output logic [4:0]    o_debug_register_number,
  output logic [NB-1:0] o_debug_address,
  input  logic [NB-1:0] i_mips_pc,
  input  logic [NB-1:0] i_mips_alu_result,
  input  logic [NB-1:0] i_mips_register_data,
  input  logic [NB-1:0] i_mips_data_memory,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_busy
);

  localparam int N_ITEMS = DBG_ITEM_MEM_BASE + TAM_DATA_MEMORY;
  localparam int IW      = $clog2(N_ITEMS);

  localparam logic [IW-1:0] L_PC       = IW'(DBG_ITEM_PC);
  localparam logic [IW-1:0] L_ALU      = IW'(DBG_ITEM_ALU);
  localparam logic [IW-1:0] L_REG_BASE = IW'(DBG_ITEM_REG_BASE);
  localparam logic [IW-1:0] L_MEM_BASE = IW'(DBG_ITEM_MEM_BASE);
  localparam logic [IW-1:0] L_LAST     = IW'(N_ITEMS - 1);

  dbg_state_e      r_state;
  logic [IW-1:0]   r_item;
  logic            r_step;
  logic            r_busy;
  logic            r_cmd_ready;
  logic [4:0]      r_reg_num;
  logic [NB-1:0]   r_addr;

  logic            w_cmd_fire;
  dbg_cmd_e        w_cmd;
  logic            w_load;
  logic            w_ser_done;
  logic [DBG_WORD_W-1:0] w_word;

  assign w_cmd_fire = i_cmd_valid & r_cmd_ready;
  assign w_cmd      = dbg_cmd_e'(i_cmd);
  assign w_load     = (r_state == ST_CAPTURE);

  // Choose the pipeline debug word for the current item; selectors are already stable.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_word = i_mips_data_memory;
    if (r_item == L_PC) begin
      w_word = i_mips_pc;
    end else if (r_item == L_ALU) begin
      w_word = i_mips_alu_result;
    end else if (r_item < L_MEM_BASE) begin
      w_word = i_mips_register_data;
    end
  end

  debug_word_serializer u_serializer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_word     (w_word),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_done     (w_ser_done)
  );

  // Controller FSM: command handling, item walking and registered debug selectors.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_item      <= '0;
      r_step      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_reg_num   <= '0;
      r_addr      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            case (w_cmd)
              DBG_CMD_STEP: begin
                r_state     <= ST_STEP;
                r_step      <= 1'b1;
                r_busy      <= 1'b1;
                r_cmd_ready <= 1'b0;
              end
              DBG_CMD_RUN: begin
                r_state     <= ST_RUN;
                r_step      <= 1'b1;
                r_busy      <= 1'b1;
                r_cmd_ready <= 1'b1;
              end
              DBG_CMD_DUMP: begin
                r_state     <= ST_SELECT;
                r_item      <= '0;
                r_busy      <= 1'b1;
                r_cmd_ready <= 1'b0;
              end
              DBG_CMD_STOP: begin
                // Nothing is running, so STOP is simply consumed.
              end
              default: begin
              end
            endcase
          end
        end
        ST_STEP: begin
          r_step  <= 1'b0;
          r_state <= ST_SELECT;
          r_item  <= '0;
        end
        ST_RUN: begin
          // A halt and a STOP in the same cycle still produce one dump.
          if ((w_cmd_fire && (w_cmd == DBG_CMD_STOP)) || i_halt) begin
            r_step      <= 1'b0;
            r_state     <= ST_SELECT;
            r_item      <= '0;
            r_cmd_ready <= 1'b0;
          end
        end
        ST_SELECT: begin
          if ((r_item >= L_REG_BASE) && (r_item < L_MEM_BASE)) begin
            r_reg_num <= 5'(r_item - L_REG_BASE);
          end
          if (r_item >= L_MEM_BASE) begin
            r_addr <= NB'(r_item - L_MEM_BASE) << 2;
          end
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_ser_done) begin
            if (r_item == L_LAST) begin
              r_state     <= ST_IDLE;
              r_item      <= '0;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
            end else begin
              r_item  <= r_item + IW'(1);
              r_state <= ST_SELECT;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_item      <= '0;
          r_step      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_step                  = r_step;
  assign o_busy                  = r_busy;
  assign o_cmd_ready             = r_cmd_ready;
  assign o_debug_register_number = r_reg_num;
  assign o_debug_address         = r_addr;

endmodule

// File: tb/tb_debug_dump_unit.sv
// Self-checking bench: a small pipeline model feeds the unit, dumps are compared
// against a byte image built directly from that model's architectural state.
module tb_debug_dump_unit;

  localparam int N_REGS  = 32;
  localparam int N_MEM   = 16;
  localparam int N_ITEMS = 2 + N_REGS + N_MEM;
  localparam int N_BYTES = 4 * N_ITEMS;

  localparam logic [1:0] C_STOP = 2'b00;
  localparam logic [1:0] C_STEP = 2'b01;
  localparam logic [1:0] C_RUN  = 2'b10;
  localparam logic [1:0] C_DUMP = 2'b11;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic        o_cmd_ready;
  logic        i_halt;
  logic        o_step;
  logic [4:0]  o_debug_register_number;
  logic [31:0] o_debug_address;
  logic [31:0] i_mips_pc, i_mips_alu_result, i_mips_register_data, i_mips_data_memory;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int step_cnt = 0;
  logic [7:0] rx_q[$];
  logic       rand_mode = 1'b0;
  logic       model_init_req;

  always #5 clk = ~clk;

  debug_dump_unit #(.NB(32), .TAM_DATA_MEMORY(N_MEM)) dut (
    .i_clk                   (clk),
    .i_reset                 (i_reset),
    .i_cmd_valid             (i_cmd_valid),
    .i_cmd                   (i_cmd),
    .o_cmd_ready             (o_cmd_ready),
    .i_halt                  (i_halt),
    .o_step                  (o_step),
    .o_debug_register_number (o_debug_register_number),
    .o_debug_address         (o_debug_address),
    .i_mips_pc               (i_mips_pc),
    .i_mips_alu_result       (i_mips_alu_result),
    .i_mips_register_data    (i_mips_register_data),
    .i_mips_data_memory      (i_mips_data_memory),
    .o_tx_data               (o_tx_data),
    .o_tx_valid              (o_tx_valid),
    .i_tx_ready              (i_tx_ready),
    .o_busy                  (o_busy)
  );

  // Pipeline model: each step advances PC by 4 and executes SLLV $3,$7,$1.
  logic [31:0] m_pc, m_alu;
  logic [31:0] m_regs [N_REGS];
  logic [31:0] m_mem  [N_MEM];

  assign i_mips_pc            = m_pc;
  assign i_mips_alu_result    = m_alu;
  assign i_mips_register_data = m_regs[o_debug_register_number];
  assign i_mips_data_memory   = m_mem[o_debug_address[5:2]];

  always @(negedge clk) begin
    if (model_init_req) begin
      m_pc  <= 32'h0;
      m_alu <= 32'h0;
      for (int r = 0; r < N_REGS; r++) m_regs[r] <= $urandom;
      m_regs[0] <= 32'h0;
      m_regs[1] <= 32'h1;
      m_regs[7] <= 32'h7;
      for (int k = 0; k < N_MEM; k++) m_mem[k] <= $urandom;
    end else if (o_step) begin
      m_pc      <= m_pc + 32'd4;
      m_regs[3] <= m_regs[7] << m_regs[1][4:0];
      m_alu     <= m_regs[7] << m_regs[1][4:0];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Byte monitor, step counter and backpressure stability check.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (prev_stall) check("stall_hold", {23'h0, o_tx_valid, o_tx_data}, {23'h0, 1'b1, prev_data});
    prev_stall = o_tx_valid && !i_tx_ready && !i_reset;
    prev_data  = o_tx_data;
    if (o_tx_valid && i_tx_ready) rx_q.push_back(o_tx_data);
    if (o_step) step_cnt++;
  end

  // Transmitter ready: always high, or about 30% low in random mode.
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_tx_ready = rand_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_expected(output logic [7:0] e [N_BYTES]);
    logic [31:0] w [N_ITEMS];
    w[0] = m_pc;
    w[1] = m_alu;
    for (int r = 0; r < N_REGS; r++) w[2 + r] = m_regs[r];
    for (int k = 0; k < N_MEM; k++) w[2 + N_REGS + k] = m_mem[k];
    for (int i = 0; i < N_ITEMS; i++)
      for (int j = 0; j < 4; j++) e[4*i + j] = 8'(w[i] >> (8 * (3 - j)));
  endtask

  function automatic logic [31:0] rx_word(input int base, input int idx);
    logic [31:0] v = 32'hDEAD_BEEF;
    if (rx_q.size() >= base + 4*idx + 4)
      v = {rx_q[base+4*idx], rx_q[base+4*idx+1], rx_q[base+4*idx+2], rx_q[base+4*idx+3]};
    return v;
  endfunction

  task automatic compare_dump(input string tag, input int base);
    logic [7:0] e [N_BYTES];
    build_expected(e);
    check({tag, "_len"}, rx_q.size() - base, N_BYTES);
    for (int i = 0; i < N_BYTES; i++)
      check($sformatf("%s_b%0d", tag, i),
            (base + i < rx_q.size()) ? {24'h0, rx_q[base+i]} : 32'hDEAD_BEEF, {24'h0, e[i]});
  endtask

  task automatic send_cmd(input logic [1:0] c, output int t_acc);
    bit done = 0;
    t_acc = -1;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (o_cmd_ready) begin
        @(posedge clk);
        #1;
        t_acc       = cyc;
        i_cmd_valid = 1'b0;
        done        = 1;
      end
    end
    if (!done) begin
      check("cmd_accept_timeout", {31'h0, o_cmd_ready}, 32'h1);
      i_cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget, output int t_idle);
    t_idle = -1;
    for (int i = 0; i < budget && t_idle < 0; i++) begin
      @(negedge clk);
      if (!o_busy) t_idle = cyc;
    end
    if (t_idle < 0) check("idle_timeout", {31'h0, o_busy}, 32'h0);
  endtask

  initial begin
    int t0, t1, base, s0, base_prev;
    int ndiff;
    i_reset        = 1'b1;
    model_init_req = 1'b1;
    i_cmd_valid    = 1'b0;
    i_cmd          = C_STOP;
    i_halt         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_step",   {31'h0, o_step},      32'h0);
    check("rst_regnum", {27'h0, o_debug_register_number}, 32'h0);
    check("rst_addr",   o_debug_address,      32'h0);
    check("rst_txdata", {24'h0, o_tx_data},   32'h0);
    check("rst_txvalid",{31'h0, o_tx_valid},  32'h0);
    check("rst_busy",   {31'h0, o_busy},      32'h0);
    check("rst_ready",  {31'h0, o_cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
    i_reset        = 1'b0;
    model_init_req = 1'b0;

    // Halt while idle must not start anything.
    i_halt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_halt = 1'b0;
    @(negedge clk);
    check("idle_halt_busy", {31'h0, o_busy}, 32'h0);

    // Plain dump from reset: PC and $0 are zero, 300-cycle latency.
    base = rx_q.size();
    send_cmd(C_DUMP, t0);
    wait_idle(2000, t1);
    check("dump0_latency", t1 - t0, 300);
    check("dump0_pc", rx_word(base, 0), 32'h0);
    check("dump0_reg0", rx_word(base, 2), 32'h0);
    compare_dump("dump0", base);

    // Three single steps, each followed by its own dump.
    for (int k = 1; k <= 3; k++) begin
      base = rx_q.size();
      s0   = step_cnt;
      send_cmd(C_STEP, t0);
      wait_idle(2000, t1);
      check($sformatf("step%0d_pulses", k), step_cnt - s0, 1);
      check($sformatf("step%0d_pc", k), rx_word(base, 0), 32'(4 * k));
      compare_dump($sformatf("step%0d", k), base);
    end

    // RUN then STOP: SLLV result in $3, no stepping during the dump.
    s0 = step_cnt;
    send_cmd(C_RUN, t0);
    repeat (6) @(posedge clk);
    base = rx_q.size();
    send_cmd(C_STOP, t0);
    check("run_steps_ge5", {31'h0, (step_cnt - s0) >= 5}, 32'h1);
    s0 = step_cnt;
    wait_idle(2000, t1);
    check("run_dump_nostep", step_cnt - s0, 0);
    check("run_reg3", rx_word(base, 5), 32'h0000_000E);
    compare_dump("run", base);
    base_prev = base;

    // Random backpressure: same bytes as the ready-high dump above.
    rand_mode = 1'b1;
    base = rx_q.size();
    send_cmd(C_DUMP, t0);
    wait_idle(5000, t1);
    rand_mode = 1'b0;
    compare_dump("bp", base);
    ndiff = 0;
    for (int i = 0; i < N_BYTES; i++)
      if (base + i >= rx_q.size() || rx_q[base+i] !== rx_q[base_prev+i]) ndiff++;
    check("bp_same_as_ready_run", ndiff, 0);

    // RUN with halt and STOP together: one dump; commands during SEND are refused.
    send_cmd(C_RUN, t0);
    repeat (3) @(posedge clk);
    base = rx_q.size();
    @(posedge clk);
    #1;
    i_halt      = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd       = C_STOP;
    @(posedge clk);
    #1;
    i_halt      = 1'b0;
    i_cmd_valid = 1'b0;
    for (int i = 0; i < 200 && rx_q.size() < base + 20; i++) @(negedge clk);
    s0 = step_cnt;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd       = C_STEP;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("send_ready%0d", i), {31'h0, o_cmd_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    wait_idle(2000, t1);
    check("halt_dump_nostep", step_cnt - s0, 0);
    compare_dump("halt", base);
    repeat (30) @(negedge clk);
    check("halt_single_dump", rx_q.size() - base, N_BYTES);
    check("halt_idle_busy", {31'h0, o_busy}, 32'h0);

    // Reset mid-SEND at byte 57, then a fresh dump from item 0.
    base = rx_q.size();
    send_cmd(C_DUMP, t0);
    for (int i = 0; i < 1000 && rx_q.size() < base + 57; i++) @(negedge clk);
    check("mid_reached57", {31'h0, rx_q.size() >= base + 57}, 32'h1);
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", {31'h0, o_tx_valid},  32'h0);
    check("mid_rst_busy",  {31'h0, o_busy},      32'h0);
    check("mid_rst_ready", {31'h0, o_cmd_ready}, 32'h1);
    check("mid_rst_step",  {31'h0, o_step},      32'h0);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    base = rx_q.size();
    send_cmd(C_DUMP, t0);
    wait_idle(2000, t1);
    check("redump_latency", t1 - t0, 300);
    compare_dump("redump", base);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
